// File: rtl/shift_reg_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receive stage.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package shift_reg_pkg;

  // Deframer FSM: waiting for a frame_start, or partway through a word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the bit counter for an n-bit word.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_out_hold.sv
// Output holding register with a valid/ready handshake toward the consumer.
// Latency: a load pulse updates o_parallel_out/o_out_valid at the next clock edge.
// Backpressure: a load that arrives while a word is held and not being taken is dropped (o_drop).
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_word, i_load       completed word and its one-cycle load strobe
//   i_out_ready          consumer accepts the held word this cycle
//   o_parallel_out       held word, stable while o_out_valid = 1
//   o_out_valid          a word is held and not yet consumed
//   o_drop               combinational: the word on i_word is being discarded this cycle
module sipo_out_hold #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_word,
  input  logic         i_load,
  input  logic         i_out_ready,
  output logic [N-1:0] o_parallel_out,
  output logic         o_out_valid,
  output logic         o_drop
);

  logic [N-1:0] r_dat;
  logic         r_vld;
  logic         w_can_load;

  // The register is free when empty, or when its word is leaving this same cycle.
  assign w_can_load = !r_vld || i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dat <= '0;
      r_vld <= 1'b0;
    end else if (i_load && w_can_load) begin
      r_dat <= i_word;
      r_vld <= 1'b1;
    end else if (r_vld && i_out_ready) begin
      // r_dat keeps its last value after the word is consumed.
      r_vld <= 1'b0;
    end
  end

  assign o_drop         = i_load && !w_can_load;
  assign o_parallel_out = r_dat;
  assign o_out_valid    = r_vld;

endmodule

// File: rtl/sipo_deframer.sv
// Reassembles an LSB-first serial stream into N-bit words aligned by frame_start.
// Latency: Nth valid bit sampled at edge t -> parallel_out/out_valid at edge t+1.
// Backpressure: one held word; a completion that finds it held and not taken is dropped, setting sticky overrun.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   serial_in, bit_valid serial bit and its qualifier
//   frame_start          current valid bit is bit 0 of a new word
//   parallel_out         assembled word (held while out_valid)
//   out_valid, out_ready handshake toward the consumer
//   busy                 a word is partially received
//   frame_err            one-cycle pulse when a partial word is abandoned by frame_start
//   overrun              sticky: a completed word was dropped
module sipo_deframer
  import shift_reg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         frame_start,
  output logic [N-1:0] parallel_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CNT_W = cnt_width(N);

  state_t             r_state;
  logic   [CNT_W-1:0] r_cnt;
  logic   [N-1:0]     r_sr;
  logic               r_done;
  logic               r_frame_err;
  logic               r_overrun;

  state_t             w_state_nxt;
  logic   [CNT_W-1:0] w_cnt_nxt;
  logic   [N-1:0]     w_sr_nxt;
  logic   [N-1:0]     w_shifted;
  logic               w_done;
  logic               w_resync;
  logic               w_drop;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  assign w_shifted = {serial_in, r_sr[N-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_done      = 1'b0;
    w_resync    = 1'b0;
    case (r_state)
      IDLE: begin
        // Valid bits without frame_start are discarded while idle.
        if (bit_valid && frame_start) begin
          w_sr_nxt    = w_shifted;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          w_sr_nxt = w_shifted;
          if (frame_start) begin
            // Restart on this bit; the partial word is abandoned.
            w_cnt_nxt = CNT_W'(1);
            w_resync  = 1'b1;
          end else if (r_cnt == CNT_W'(N - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_done      <= w_done;
      r_frame_err <= w_resync;
      r_overrun   <= r_overrun || w_drop;
    end
  end

  // r_done marks the cycle in which r_sr holds the just-completed word; a new
  // frame may start that same cycle because the hold register samples r_sr
  // before it is overwritten.
  sipo_out_hold #(
    .N(N)
  ) u_out_hold (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_word         (r_sr),
    .i_load         (r_done),
    .i_out_ready    (out_ready),
    .o_parallel_out (parallel_out),
    .o_out_valid    (out_valid),
    .o_drop         (w_drop)
  );

  assign busy      = (r_state == SHIFT);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-to-parallel receive stage that sits directly downstream of the team's PISO serializer and reassembles its LSB-first bit stream into N-bit words. Word boundaries come from a frame_start marker aligned to bit 0. Completed words are held in an output register with a valid/ready handshake toward the consuming logic. The stage also reports overruns and framing restarts.

## Interface
- N, default 4: word width in bits; legal range N ≥ 2.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- serial_in  in  1  serial data bit, LSB first; sampled only when bit_valid = 1.
- bit_valid  in  1  qualifies serial_in for this cycle.
- frame_start  in  1  marks the current valid bit as bit 0 of a word; ignored when bit_valid = 0.
- parallel_out  out  N  assembled word, held while out_valid = 1.
- out_valid  out  1  parallel_out contains an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- busy  out  1  a word is partially received (state SHIFT).
- frame_err  out  1  one-cycle pulse when a partial word is abandoned by a new frame_start.
- overrun  out  1  sticky flag: a completed word was dropped; cleared only by reset.

## Operation
- **States:** IDLE and SHIFT, plus bit counter cnt of width $clog2(N) and an N-bit shift register sr.
- **Shift rule:** on every accepted bit, sr <= {serial_in, sr[N-1:1]}. After N bits, sr equals the transmitted word, so bit 0 is the first bit received.
- **IDLE:**
  - bit_valid & frame_start: shift the bit in, cnt <= 1, go to SHIFT.
  - Valid bits without frame_start are discarded.
- **SHIFT:**
  - bit_valid & !frame_start: shift the bit in, cnt <= cnt+1.
  - On the Nth bit (cnt == N-1 on entry): the word completes and the state returns to IDLE.
  - bit_valid & frame_start: resync. Discard the partial word, take this bit as bit 0, cnt <= 1, stay in SHIFT, pulse frame_err.
  - bit_valid = 0: hold state, cnt and sr.
- **Word completion:** the complete word is the final sr value including the Nth bit.
  - If out_valid = 0, or out_valid & out_ready in the same cycle: parallel_out <= word and out_valid <= 1.
  - Otherwise, with out_valid & !out_ready: the new word is dropped, parallel_out is unchanged, and overrun <= 1.
- **Handshake:**
  - out_valid & out_ready with no completion that cycle: out_valid <= 0 next cycle. parallel_out keeps its last value.
  - out_valid never deasserts without out_ready.
  - parallel_out is stable while out_valid = 1.
- **busy** = (state == SHIFT).
- **Reset values:** state IDLE, cnt 0, sr 0, parallel_out 0, out_valid 0, busy 0, frame_err 0, overrun 0.
- **Reset during a partial word:** the partial word is lost, with no frame_err and no output.

## Timing
- Nth valid bit sampled at edge t: parallel_out and out_valid are updated at edge t+1.
- Latency from frame_start to out_valid is N cycles when bits are back-to-back.
- Throughput is one word per N valid bits, with no dead cycle between words. frame_start may coincide with the cycle immediately after a completion.
- frame_err is high for exactly the cycle following the resync edge.
- overrun rises at the edge after the dropped completion and stays high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package shift_reg_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - localparam CNT_W = $clog2(N) helper function.
- One sub-module, sipo_out_hold, contains the output holding register. Its inputs are word and load pulse, plus out_ready. Its outputs are parallel_out, out_valid and drop. Drop feeds the overrun flag.
- The FSM, counter and shift register live in the top module.

## Test plan
All scenarios use N = 4.
1. **Single word:** frame_start on the first bit; bits 1,1,0,1 back-to-back; out_ready = 1. Expect parallel_out = 4'hB and out_valid high one cycle after the 4th bit, then low the next cycle. overrun = 0.
2. **Gapped bits:** send 4'h6 with bit_valid low for 2 cycles between each bit. Expect busy high throughout and 4'h6 delivered one cycle after the last bit.
3. **Backpressure and overrun:** out_ready = 0; send 4'hA then 4'h5. Expect parallel_out to stay 4'hA with out_valid held and overrun = 1 after the 2nd word completes. Then raise out_ready: out_valid drops and overrun stays 1.
4. **Same-cycle load and drain:** words 4'h3 and 4'hC back-to-back; out_ready asserted exactly on the completion cycle of 4'hC. Expect 4'hC loaded, out_valid continuously high, overrun = 0.
5. **Resync:** two bits of a word, then frame_start with a new word 4'h9. Expect a one-cycle frame_err pulse and only 4'h9 delivered.
6. **Reset mid-word:** assert reset after 2 bits, then send 4'h7 with frame_start. Expect all outputs 0 after reset, no frame_err, and 4'h7 delivered normally.
